// File: rtl/counter_pkg.sv
// Shared constants for the modulo up/down counter family.
// Direction and boundary-mode encodings used by the counter and its next-state logic.
package counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  localparam bit   MODE_WRAP = 1'b0;
  localparam bit   MODE_SAT  = 1'b1;

endpackage

// File: rtl/mod_counter_next.sv
// Next-count and boundary detection for mod_counter; purely combinational, zero latency.
// Priority clear > load > en; no backpressure, the result is consumed every cycle.
module mod_counter_next
  import counter_pkg::*;
#(
  parameter int                WIDTH    = 8,
  parameter logic [WIDTH-1:0]  MAX_L    = '1,
  parameter bit                SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count_nxt,
  output logic             boundary
);

  always_comb begin
    count_nxt = count;
    boundary  = 1'b0;
    if (clear) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > MAX_L) ? MAX_L : load_val;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        // >= keeps the range closed even if count were ever above MAX_L
        if (count >= MAX_L) begin
          boundary  = 1'b1;
          count_nxt = (SATURATE == MODE_SAT) ? count : '0;
        end else begin
          count_nxt = count + 1'b1;
        end
      end else begin
        if (count == '0) begin
          boundary  = 1'b1;
          count_nxt = (SATURATE == MODE_SAT) ? count : MAX_L;
        end else begin
          count_nxt = count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with load, clear, terminal-count pulse and sticky overflow.
// One-cycle latency from inputs to registered outputs; no backpressure, steps every enabled cycle.
module mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH     = 8,
  parameter longint MAX_VALUE = (64'sd1 <<< WIDTH) - 64'sd1,
  parameter bit     SATURATE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH %0d outside 2..32", WIDTH);
  end
  if (MAX_VALUE < 0 || MAX_VALUE > ((64'sd1 <<< WIDTH) - 64'sd1)) begin : g_bad_max
    $error("mod_counter: MAX_VALUE %0d does not fit in WIDTH %0d", MAX_VALUE, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_L = MAX_VALUE[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d, count_nxt;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             boundary;

  mod_counter_next #(
    .WIDTH    (WIDTH),
    .MAX_L    (MAX_L),
    .SATURATE (SATURATE)
  ) u_next (
    .count     (count_q),
    .en        (en),
    .up_dn     (up_dn),
    .load      (load),
    .load_val  (load_val),
    .clear     (clear),
    .count_nxt (count_nxt),
    .boundary  (boundary)
  );

  // boundary is never raised on clear/load cycles, so only clear needs masking here
  always_comb begin
    count_d = count_nxt;
    tc_d    = boundary;
    ovf_d   = (ovf_q | boundary) & ~clear;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: three configurations (8-bit wrap, MAX 9 wrap, MAX 9 saturate) share stimulus.
// Each is compared against an integer-arithmetic reference model, plus vector table and corner sequences.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       clear = 1'b0;

  logic [7:0] dc [3];
  logic       dt [3];
  logic       dov[3];

  int checks = 0;
  int errors = 0;

  int mx [3] = '{255, 9, 9};
  bit msat[3] = '{1'b0, 1'b0, 1'b1};
  int mc [3];
  int mt [3];
  int mo [3];

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(8)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clear(clear), .count(dc[0]), .tc(dt[0]), .ovf(dov[0])
  );
  mod_counter #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clear(clear), .count(dc[1]), .tc(dt[1]), .ovf(dov[1])
  );
  mod_counter #(.WIDTH(8), .MAX_VALUE(9), .SATURATE(1'b1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clear(clear), .count(dc[2]), .tc(dt[2]), .ovf(dov[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: counting is arithmetic on the closed range 0..max; stepping outside it is a boundary event.
  task automatic model_step(input bit r, input bit c, input bit l, input bit e, input bit u, input int lv);
    for (int i = 0; i < 3; i++) begin
      if (!r || c) begin
        mc[i] = 0; mt[i] = 0; mo[i] = 0;
      end else if (l) begin
        mc[i] = (lv > mx[i]) ? mx[i] : lv;
        mt[i] = 0;
      end else if (e) begin
        int tgt;
        tgt = u ? mc[i] + 1 : mc[i] - 1;
        if (tgt < 0 || tgt > mx[i]) begin
          mt[i] = 1; mo[i] = 1;
          if (!msat[i]) mc[i] = (tgt + mx[i] + 1) % (mx[i] + 1);
        end else begin
          mc[i] = tgt; mt[i] = 0;
        end
      end else begin
        mt[i] = 0;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit l, input bit e, input bit u, input logic [7:0] lv);
    reset_n = r; clear = c; load = l; en = e; up_dn = u; load_val = lv;
    @(posedge clk);
    model_step(r, c, l, e, u, int'(lv));
    #1;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s.cnt%0d", tag, i), int'(dc[i]), mc[i]);
      chk($sformatf("%s.tc%0d", tag, i), int'(dt[i]), mt[i]);
      chk($sformatf("%s.ovf%0d", tag, i), int'(dov[i]), mo[i]);
    end
  endtask

  typedef struct {
    bit         r, c, l, e, u;
    logic [7:0] lv;
    int         cnt, tc, ovf;
  } vec_t;

  initial begin
    vec_t vt[13];
    int   tc_sum;
    int   last_tc;

    // Vectors for the MAX_VALUE=9 wrap instance, starting from reset.
    vt[0]  = '{0,0,0,1,1,  8'd0,   0,0,0};
    vt[1]  = '{1,0,0,1,0,  8'd0,   9,1,1};
    vt[2]  = '{1,0,0,1,0,  8'd0,   8,0,1};
    vt[3]  = '{1,0,0,1,0,  8'd0,   7,0,1};
    vt[4]  = '{1,0,1,0,0,  8'd200, 9,0,1};
    vt[5]  = '{1,0,0,1,1,  8'd0,   0,1,1};
    vt[6]  = '{1,0,1,0,1,  8'd5,   5,0,1};
    vt[7]  = '{1,1,1,1,1,  8'd3,   0,0,0};
    vt[8]  = '{1,0,1,1,1,  8'd7,   7,0,0};
    vt[9]  = '{1,0,0,0,1,  8'd0,   7,0,0};
    vt[10] = '{1,0,0,1,1,  8'd0,   8,0,0};
    vt[11] = '{0,0,0,1,1,  8'd0,   0,0,0};
    vt[12] = '{1,0,0,1,1,  8'd0,   1,0,0};

    for (int k = 0; k < 13; k++) begin
      cyc(vt[k].r, vt[k].c, vt[k].l, vt[k].e, vt[k].u, vt[k].lv);
      chk($sformatf("vec%0d.count", k), int'(dc[1]), vt[k].cnt);
      chk($sformatf("vec%0d.tc", k), int'(dt[1]), vt[k].tc);
      chk($sformatf("vec%0d.ovf", k), int'(dov[1]), vt[k].ovf);
      check_model($sformatf("vec%0d", k));
    end

    // Full 8-bit wrap: 256 up steps from reset, tc only on the step that lands on 0.
    cyc(0, 0, 0, 0, 1, 8'd0);
    chk("wrap256.reset_count", int'(dc[0]), 0);
    tc_sum = 0;
    last_tc = 0;
    for (int s = 1; s <= 256; s++) begin
      cyc(1, 0, 0, 1, 1, 8'd0);
      chk($sformatf("wrap256.count%0d", s), int'(dc[0]), s % 256);
      tc_sum += int'(dt[0]);
      if (s == 256) last_tc = int'(dt[0]);
    end
    chk("wrap256.tc_total", tc_sum, 1);
    chk("wrap256.tc_on_zero", last_tc, 1);
    chk("wrap256.ovf", int'(dov[0]), 1);
    check_model("wrap256");

    // Saturating MAX 9: 12 up then 12 down, tc on each held boundary step.
    cyc(0, 0, 0, 0, 1, 8'd0);
    tc_sum = 0;
    for (int s = 0; s < 12; s++) begin
      cyc(1, 0, 0, 1, 1, 8'd0);
      tc_sum += int'(dt[2]);
      chk($sformatf("satup.tc%0d", s), int'(dt[2]), (s >= 9) ? 1 : 0);
    end
    chk("satup.count", int'(dc[2]), 9);
    chk("satup.tc_total", tc_sum, 3);
    chk("satup.ovf", int'(dov[2]), 1);
    tc_sum = 0;
    for (int s = 0; s < 12; s++) begin
      cyc(1, 0, 0, 1, 0, 8'd0);
      tc_sum += int'(dt[2]);
      chk($sformatf("satdn.tc%0d", s), int'(dt[2]), (s >= 9) ? 1 : 0);
    end
    chk("satdn.count", int'(dc[2]), 0);
    chk("satdn.tc_total", tc_sum, 3);
    check_model("sat");

    // Reset mid-count at 123 with en high, then first step from 0.
    cyc(1, 0, 1, 0, 1, 8'd123);
    chk("rst123.loaded", int'(dc[0]), 123);
    cyc(0, 0, 0, 1, 1, 8'd0);
    chk("rst123.count", int'(dc[0]), 0);
    chk("rst123.tc", int'(dt[0]), 0);
    chk("rst123.ovf", int'(dov[0]), 0);
    cyc(1, 0, 0, 1, 1, 8'd0);
    chk("rst123.first_step", int'(dc[0]), 1);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit r, c, l, e, u;
      r = ($urandom_range(99) >= 2);
      c = ($urandom_range(99) < 4);
      l = ($urandom_range(99) < 10);
      e = ($urandom_range(99) < 75);
      u = ($urandom_range(99) < ((n / 300) % 2 == 0 ? 80 : 20));
      cyc(r, c, l, e, u, 8'($urandom_range(255)));
      check_model($sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
